// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches 32-bit words for the selected program from the
// microcode ROM, decodes them and issues one gate at a time to the gate engine.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, prog_sel        start pulse and program id (taken only when idle)
//   rom_prog_id, rom_addr  ROM address, rom_data is the same-cycle word
//   gate_valid/ready       gate command handshake, payload gate_op/tgt/ctl/imm
//   gate_done              engine completion pulse for the accepted gate
//   busy, done, err        status, err_code holds the cause of the last error
//   instr_count            gates issued in the current or last run
module microcode_sequencer #(
    parameter int NUM_QUBITS   = 4,
    parameter int WAIT_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  prog_sel,
    output logic [1:0]  rom_prog_id,
    output logic [7:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic        gate_valid,
    input  logic        gate_ready,
    output logic [3:0]  gate_op,
    output logic [3:0]  gate_tgt,
    output logic [3:0]  gate_ctl,
    output logic [15:0] gate_imm,
    input  logic        gate_done,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [7:0]  instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DONE
    } state_e;

    localparam logic [31:0] NQ       = 32'(NUM_QUBITS);
    localparam logic [31:0] TMO_LAST = 32'(WAIT_TIMEOUT - 1);

    state_e      state_q;
    logic [27:0] instr_q;
    logic [1:0]  prog_q;
    logic [7:0]  addr_q;
    logic        valid_q;
    logic [3:0]  op_q, tgt_q, ctl_q;
    logic [15:0] imm_q;
    logic        busy_q, done_q, err_q;
    logic [2:0]  code_q;
    logic [7:0]  cnt_q;
    logic [31:0] tmo_q;

    // The low nibble of each word carries no information.
    logic unused_low;
    assign unused_low = ^rom_data[3:0];

    logic [3:0] w_op, w_tgt, w_ctl;
    logic       two_q, tgt_bad, ctl_bad;
    logic [2:0] dec_code_d;

    assign w_op    = instr_q[27:24];
    assign w_tgt   = instr_q[23:20];
    assign w_ctl   = instr_q[19:16];
    assign two_q   = (w_op == 4'd4) || (w_op == 4'd5) || (w_op == 4'd6);
    assign tgt_bad = {28'd0, w_tgt} >= NQ;
    assign ctl_bad = {28'd0, w_ctl} >= NQ;

    // Error classification of the word in DECODE; 0 means no error.
    always_comb begin
        dec_code_d = 3'd0;
        if (w_op >= 4'd7 && w_op <= 4'd14) begin
            dec_code_d = 3'd1;
        end else if (w_op != 4'd0 && w_op != 4'd15) begin
            if (tgt_bad || (two_q && ctl_bad)) begin
                dec_code_d = 3'd2;
            end else if (two_q && w_tgt == w_ctl) begin
                dec_code_d = 3'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            prog_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            op_q    <= '0;
            tgt_q   <= '0;
            ctl_q   <= '0;
            imm_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        prog_q  <= prog_sel;
                        addr_q  <= 8'd0;
                        err_q   <= 1'b0;
                        code_q  <= 3'd0;
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    instr_q <= rom_data[31:4];
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (dec_code_d != 3'd0) begin
                        err_q   <= 1'b1;
                        code_q  <= dec_code_d;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (w_op == 4'd0) begin
                        // NOP at the last address cannot advance.
                        if (addr_q == 8'hFF) begin
                            err_q   <= 1'b1;
                            code_q  <= 3'd4;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            addr_q  <= addr_q + 8'd1;
                            state_q <= S_FETCH;
                        end
                    end else if (w_op == 4'd15) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        op_q    <= w_op;
                        tgt_q   <= w_tgt;
                        ctl_q   <= w_ctl;
                        imm_q   <= instr_q[15:0];
                        valid_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (gate_ready) begin
                        valid_q <= 1'b0;
                        if (cnt_q != 8'hFF) begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                        tmo_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (gate_done) begin
                        if (addr_q == 8'hFF) begin
                            err_q   <= 1'b1;
                            code_q  <= 3'd4;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            addr_q  <= addr_q + 8'd1;
                            state_q <= S_FETCH;
                        end
                    end else if (WAIT_TIMEOUT != 0 && tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        code_q  <= 3'd5;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_prog_id = prog_q;
    assign rom_addr    = addr_q;
    assign gate_valid  = valid_q;
    assign gate_op     = op_q;
    assign gate_tgt    = tgt_q;
    assign gate_ctl    = ctl_q;
    assign gate_imm    = imm_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = code_q;
    assign instr_count = cnt_q;

endmodule
